// File: rtl/booth_pkg.sv
// Shared types and elaboration-time helpers for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        DONE     = 2'd2
    } fsm_state_e;

    function automatic bit radix_legal(input int radix);
        return (radix == 2) || (radix == 4) || (radix == 8) || (radix == 16);
    endfunction

    // Falls back to 1 for an illegal radix so widths stay sane until the check fires.
    function automatic int rb_of(input int radix);
        int rb;
        rb = 1;
        for (int i = 1; i <= 4; i++) begin
            if ((1 << i) == radix) rb = i;
        end
        return rb;
    endfunction

    // ceil((n+1)/rb)*rb: room for a sign bit above an unsigned operand.
    function automatic int ext_width(input int n, input int rb);
        return ((n + rb) / rb) * rb;
    endfunction

    function automatic int iter_of(input int n, input int rb);
        return ext_width(n, rb) / rb;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth digit selection: turns an (RB+1)-bit window into digit*B.
module booth_recoder #(
    parameter int RB  = 2,
    parameter int EXT = 10
) (
    input  logic [RB:0]               window_i,
    input  logic signed [EXT-1:0]     b_i,
    output logic signed [EXT+RB-1:0]  multiple_o
);

    logic signed [EXT+RB-1:0] b_wide;

    assign b_wide = {{RB{b_i[EXT-1]}}, b_i};

    // digit = -w[RB]*2^(RB-1) + sum w[i]*2^(i-1) (i=1..RB-1) + w[0]
    always_comb begin
        multiple_o = '0;
        if (window_i[0]) multiple_o = b_wide;
        for (int i = 1; i < RB; i++) begin
            if (window_i[i]) multiple_o = multiple_o + (b_wide <<< (i - 1));
        end
        if (window_i[RB]) multiple_o = multiple_o - (b_wide <<< (RB - 1));
    end

endmodule

// File: rtl/booth_multiplier_hs.sv
// Multi-cycle radix-configurable Booth multiplier with valid/ready on both sides.
// Optional BOOTH_MUL_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module booth_multiplier_hs
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RADIX      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clk_en_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     operand_a_i,
    input  logic [DATA_WIDTH-1:0]     operand_b_i,
    input  logic                      signed_a_i,
    input  logic                      signed_b_i,
    output logic [2*DATA_WIDTH-1:0]   result_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    localparam int N     = DATA_WIDTH;
    localparam int RB    = rb_of(RADIX);
    localparam int EXT   = ext_width(N, RB);
    localparam int ITER  = iter_of(N, RB);
    localparam int PW    = EXT + RB;
    localparam int SRW   = PW + EXT + 1;
    localparam int CNT_W = $clog2(ITER + 1);

    if (!radix_legal(RADIX) || (DATA_WIDTH < 4)) begin : g_param_check
        $error("booth_multiplier_hs: RADIX must be 2/4/8/16 and DATA_WIDTH >= 4");
    end

    fsm_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2*N-1:0]           result_q, result_d;
    logic signed [PW-1:0]     p_q, p_d;
    logic [EXT-1:0]           a_q, a_d;
    logic                     l_q, l_d;
    logic signed [EXT-1:0]    b_q, b_d;

    logic [EXT-1:0]           a_ext;
    logic signed [EXT-1:0]    b_ext;
    logic signed [PW-1:0]     multiple;
    logic signed [PW-1:0]     sum;
    logic signed [SRW-1:0]    shifted;

    assign a_ext = signed_a_i ? {{(EXT-N){operand_a_i[N-1]}}, operand_a_i}
                              : {{(EXT-N){1'b0}}, operand_a_i};
    assign b_ext = signed_b_i ? {{(EXT-N){operand_b_i[N-1]}}, operand_b_i}
                              : {{(EXT-N){1'b0}}, operand_b_i};

    booth_recoder #(
        .RB  (RB),
        .EXT (EXT)
    ) u_recoder (
        .window_i   ({a_q[RB-1:0], l_q}),
        .b_i        (b_q),
        .multiple_o (multiple)
    );

    // One Booth step: accumulate, then shift {P, A, L} right by RB bits.
    assign sum     = p_q + multiple;
    assign shifted = $signed({sum, a_q, l_q}) >>> RB;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        p_d      = p_q;
        a_d      = a_q;
        l_d      = l_q;
        b_d      = b_q;
        if (clk_en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        p_d   = '0;
                        a_d   = a_ext;
                        l_d   = 1'b0;
                        b_d   = b_ext;
                        cnt_d = '0;
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
                        if ((a_ext == '0) || (b_ext == '0)) begin
                            state_d  = DONE;
                            result_d = '0;
                        end else begin
                            state_d = MULTIPLY;
                        end
`else
                        state_d = MULTIPLY;
`endif
                    end
                end
                MULTIPLY: begin
                    p_d   = shifted[SRW-1 -: PW];
                    a_d   = shifted[EXT:1];
                    l_d   = shifted[0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d  = DONE;
                        result_d = shifted[2*N:1];
                    end
                end
                DONE: begin
                    if (ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Working registers are fully reloaded on accept, so they need no reset.
    always_ff @(posedge clk_i) begin
        p_q <= p_d;
        a_q <= a_d;
        l_q <= l_d;
        b_q <= b_d;
    end

    assign ready_o  = (state_q == IDLE) & clk_en_i;
    assign valid_o  = (state_q == DONE);
    assign busy_o   = (state_q != IDLE);
    assign result_o = result_q;

endmodule
